multicycle_decoder: RTL and testbench

MULTICYCLE_DECODER -- requirements
Module: multicycle_decoder

---
 rtl/multicycle_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_multicycle_decoder.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_decoder.sv
// multicycle_decoder: control FSM for a multicycle ARM-style datapath.
// Sequences fetch / decode / memory / ALU / branch steps.
// Inputs : clk, reset_n (sync, active-low), op, funct, rd, cond_ex, mem_ready.
// Outputs: datapath enables and selects, illegal, instr_done, state_o.
// Optional: define MCDEC_BL_EN to add the branch-and-link (LINK) step.
module multicycle_decoder #(
    parameter int ALU_CTRL_W = 3,
    parameter int CV_OPS     = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            op,
    input  logic [5:0]            funct,
    input  logic [3:0]            rd,
    input  logic                  cond_ex,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  mem_w,
    output logic                  reg_w,
    output logic                  alu_src_a,
    output logic                  illegal,
    output logic                  instr_done,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            imm_src,
    output logic [1:0]            result_src,
    output logic [1:0]            flag_w,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [3:0]            state_o
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        LINK     = 4'd10
    } state_e;

    state_e state_q, state_d;

    // Data-processing command decode
    logic [3:0]            cmd;
    logic [2:0]            cmd_code;
    logic                  cmd_known;
    logic                  cmd_illegal;
    logic                  cmd_is_cmp;
    logic                  cmd_arith;
    logic                  s_eff;
    logic [ALU_CTRL_W-1:0] alu_ctrl_val;

    assign cmd = funct[4:1];

    always_comb begin
        cmd_code  = 3'd0;
        cmd_known = 1'b1;
        case (cmd)
            4'b0100: cmd_code = 3'd0;
            4'b0010: cmd_code = 3'd1;
            4'b1010: cmd_code = 3'd1;
            4'b0000: cmd_code = 3'd2;
            4'b1100: cmd_code = 3'd3;
            4'b0001: cmd_code = 3'd4;
            4'b1101: cmd_code = 3'd5;
            default: cmd_known = 1'b0;
        endcase
    end

    // Codes that do not fit in alu_control are treated as unsupported
    assign cmd_illegal  = !cmd_known ||
                          (int'(cmd_code) >= (1 << ALU_CTRL_W));
    assign cmd_is_cmp   = (cmd == 4'b1010);
    assign cmd_arith    = (cmd == 4'b0100) || (cmd == 4'b0010) ||
                          cmd_is_cmp;
    assign s_eff        = funct[0] || cmd_is_cmp;
    assign alu_ctrl_val = cmd_illegal ? '0 : ALU_CTRL_W'(cmd_code);

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (op)
                    2'b00:   state_d = funct[5] ? EXECI : EXECR;
                    2'b01:   state_d = MEMADR;
`ifdef MCDEC_BL_EN
                    2'b10:   state_d = funct[4] ? LINK : BRANCH;
`else
                    2'b10:   state_d = BRANCH;
`endif
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  if (mem_ready) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (mem_ready) state_d = FETCH;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
`ifdef MCDEC_BL_EN
            LINK:     state_d = BRANCH;
`endif
            default:  state_d = FETCH;
        endcase
    end

    // Output decode (ungated)
    logic                  pc_write_c, adr_src_c, ir_write_c, mem_w_c;
    logic                  reg_w_c, alu_src_a_c, illegal_c, instr_done_c;
    logic [1:0]            alu_src_b_c, imm_src_c, result_src_c, flag_w_c;
    logic [ALU_CTRL_W-1:0] alu_control_c;

    always_comb begin
        pc_write_c    = 1'b0;
        adr_src_c     = 1'b0;
        ir_write_c    = 1'b0;
        mem_w_c       = 1'b0;
        reg_w_c       = 1'b0;
        alu_src_a_c   = 1'b0;
        illegal_c     = 1'b0;
        instr_done_c  = 1'b0;
        alu_src_b_c   = 2'b00;
        imm_src_c     = 2'b00;
        result_src_c  = 2'b00;
        flag_w_c      = 2'b00;
        alu_control_c = '0;
        case (state_q)
            FETCH: begin
                alu_src_a_c  = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                ir_write_c   = mem_ready;
                pc_write_c   = mem_ready;
            end
            DECODE: begin
                alu_src_a_c  = 1'b1;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                illegal_c    = (op == 2'b11) ||
                               ((op == 2'b00) && cmd_illegal);
                instr_done_c = (op == 2'b11);
            end
            MEMADR: begin
                alu_src_b_c = 2'b01;
                imm_src_c   = 2'b01;
            end
            MEMREAD: adr_src_c = 1'b1;
            MEMWB: begin
                result_src_c = 2'b01;
                reg_w_c      = cond_ex;
                instr_done_c = 1'b1;
            end
            MEMWRITE: begin
                adr_src_c    = 1'b1;
                mem_w_c      = cond_ex;
                instr_done_c = mem_ready;
            end
            EXECR, EXECI: begin
                if (state_q == EXECI) alu_src_b_c = 2'b01;
                alu_control_c = alu_ctrl_val;
                flag_w_c[1]   = s_eff && cond_ex && !cmd_illegal;
                flag_w_c[0]   = flag_w_c[1] && (CV_OPS != 0) &&
                                cmd_arith;
            end
            ALUWB: begin
                reg_w_c      = cond_ex && !cmd_is_cmp && !cmd_illegal;
                pc_write_c   = reg_w_c && (rd == 4'd15);
                instr_done_c = 1'b1;
            end
            BRANCH: begin
                alu_src_b_c  = 2'b01;
                imm_src_c    = 2'b10;
                result_src_c = 2'b10;
                pc_write_c   = cond_ex;
                instr_done_c = 1'b1;
            end
`ifdef MCDEC_BL_EN
            LINK: begin
                result_src_c = 2'b10;
                imm_src_c    = 2'b11;
                reg_w_c      = cond_ex;
            end
`endif
            default: ;
        endcase
    end

    // Everything is forced low while reset is held
    assign pc_write    = reset_n ? pc_write_c    : 1'b0;
    assign adr_src     = reset_n ? adr_src_c     : 1'b0;
    assign ir_write    = reset_n ? ir_write_c    : 1'b0;
    assign mem_w       = reset_n ? mem_w_c       : 1'b0;
    assign reg_w       = reset_n ? reg_w_c       : 1'b0;
    assign alu_src_a   = reset_n ? alu_src_a_c   : 1'b0;
    assign illegal     = reset_n ? illegal_c     : 1'b0;
    assign instr_done  = reset_n ? instr_done_c  : 1'b0;
    assign alu_src_b   = reset_n ? alu_src_b_c   : 2'b00;
    assign imm_src     = reset_n ? imm_src_c     : 2'b00;
    assign result_src  = reset_n ? result_src_c  : 2'b00;
    assign flag_w      = reset_n ? flag_w_c      : 2'b00;
    assign alu_control = reset_n ? alu_control_c : '0;
    assign state_o     = reset_n ? state_q       : 4'd0;

endmodule

// File: tb/tb_multicycle_decoder.sv
// tb_multicycle_decoder: directed checks of the multicycle decoder FSM.
// Two instances: default widths, and ALU_CTRL_W=2 with CV_OPS=0.
module tb_multicycle_decoder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] op = 2'b00;
    logic [5:0] funct = 6'd0;
    logic [3:0] rd = 4'd0;
    logic       cond_ex = 1'b1;
    logic       mem_ready = 1'b1;

    logic       pc_write, adr_src, ir_write, mem_w, reg_w;
    logic       alu_src_a, illegal, instr_done;
    logic [1:0] alu_src_b, imm_src, result_src, flag_w;
    logic [2:0] alu_control;
    logic [3:0] state_o;

    logic       w2_pc_write, w2_adr_src, w2_ir_write, w2_mem_w, w2_reg_w;
    logic       w2_alu_src_a, w2_illegal, w2_instr_done;
    logic [1:0] w2_alu_src_b, w2_imm_src, w2_result_src, w2_flag_w;
    logic [1:0] w2_alu_control;
    logic [3:0] w2_state_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_decoder #(.ALU_CTRL_W(3), .CV_OPS(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .rd(rd),
        .cond_ex(cond_ex), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
        .mem_w(mem_w), .reg_w(reg_w), .alu_src_a(alu_src_a),
        .illegal(illegal), .instr_done(instr_done),
        .alu_src_b(alu_src_b), .imm_src(imm_src),
        .result_src(result_src), .flag_w(flag_w),
        .alu_control(alu_control), .state_o(state_o)
    );

    multicycle_decoder #(.ALU_CTRL_W(2), .CV_OPS(0)) u_w2 (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .rd(rd),
        .cond_ex(cond_ex), .mem_ready(mem_ready),
        .pc_write(w2_pc_write), .adr_src(w2_adr_src),
        .ir_write(w2_ir_write), .mem_w(w2_mem_w), .reg_w(w2_reg_w),
        .alu_src_a(w2_alu_src_a), .illegal(w2_illegal),
        .instr_done(w2_instr_done), .alu_src_b(w2_alu_src_b),
        .imm_src(w2_imm_src), .result_src(w2_result_src),
        .flag_w(w2_flag_w), .alu_control(w2_alu_control),
        .state_o(w2_state_o)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_ready = 1'b1; cond_ex = 1'b1;
        op = 2'b00; funct = 6'd0;
        tick(); tick();
        checks++;
        if ({pc_write, adr_src, ir_write, mem_w, reg_w, alu_src_a,
             illegal, instr_done, alu_src_b, imm_src, result_src,
             flag_w, alu_control, state_o} !== 23'd0) begin
            errors++;
            $display("FAIL reset_gate: outputs not all zero, ir_write=%0b pc_write=%0b state=%0d",
                     ir_write, pc_write, state_o);
        end
        checks++;
        if ({w2_pc_write, w2_adr_src, w2_ir_write, w2_mem_w, w2_reg_w,
             w2_alu_src_a, w2_illegal, w2_instr_done, w2_alu_src_b,
             w2_imm_src, w2_result_src, w2_flag_w, w2_alu_control,
             w2_state_o} !== 22'd0) begin
            errors++;
            $display("FAIL reset_gate_w2: outputs not all zero, state=%0d",
                     w2_state_o);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if ({state_o, ir_write, pc_write, alu_src_a, alu_src_b,
             result_src, adr_src} !== {4'd0, 1'b1, 1'b1, 1'b1, 2'b10,
                                       2'b10, 1'b0}) begin
            errors++;
            $display("FAIL reset_fetch: state=%0d ir=%0b pc=%0b a=%0b b=%0b rs=%0b, need 0 1 1 1 10 10",
                     state_o, ir_write, pc_write, alu_src_a, alu_src_b,
                     result_src);
        end
    endtask

    task automatic test_fetch_wait();
        mem_ready = 1'b0;
        #1;
        checks++;
        if ({state_o, ir_write, pc_write} !== 6'd0) begin
            errors++;
            $display("FAIL fetch_wait: state=%0d ir=%0b pc=%0b need 0 0 0",
                     state_o, ir_write, pc_write);
        end
        tick();
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL fetch_hold: state=%0d need 0", state_o);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({ir_write, pc_write} !== 2'b11) begin
            errors++;
            $display("FAIL fetch_ready: ir=%0b pc=%0b need 1 1",
                     ir_write, pc_write);
        end
    endtask

    task automatic test_add();
        int exp_st[5] = '{0, 1, 6, 8, 0};
        int exp_rw[5] = '{0, 0, 0, 1, 0};
        op = 2'b00; funct = 6'b001000; rd = 4'd1;
        cond_ex = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({state_o, reg_w} !== {4'(exp_st[i]), 1'(exp_rw[i])}) begin
                errors++;
                $display("FAIL add_c%0d: state/reg_w=%0d/%0b need %0d/%0d",
                         i, state_o, reg_w, exp_st[i], exp_rw[i]);
            end
            if (i == 2) begin
                checks++;
                if ({alu_control, flag_w, alu_src_a, alu_src_b} !==
                    {3'd0, 2'b00, 1'b0, 2'b00}) begin
                    errors++;
                    $display("FAIL add_exec: ctl=%0d fw=%0b a=%0b b=%0b need 0 00 0 00",
                             alu_control, flag_w, alu_src_a, alu_src_b);
                end
            end
            if (i == 3) begin
                checks++;
                if ({instr_done, pc_write, result_src} !== 4'b1000) begin
                    errors++;
                    $display("FAIL add_wb: done=%0b pc=%0b rs=%0b need 1 0 00",
                             instr_done, pc_write, result_src);
                end
            end
            if (i != 4) tick();
        end
    endtask

    task automatic test_ldr();
        int mr[9]     = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        int exp_st[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
        op = 2'b01; funct = 6'b000001; rd = 4'd2; cond_ex = 1'b1;
        for (int i = 0; i < 9; i++) begin
            mem_ready = mr[i][0];
            #1;
            checks++;
            if ({state_o, reg_w} !== {4'(exp_st[i]), (i == 7)}) begin
                errors++;
                $display("FAIL ldr_c%0d: state/reg_w=%0d/%0b need %0d/%0b",
                         i, state_o, reg_w, exp_st[i], (i == 7));
            end
            if (i == 2) begin
                checks++;
                if ({alu_src_a, alu_src_b, imm_src, alu_control} !==
                    {1'b0, 2'b01, 2'b01, 3'd0}) begin
                    errors++;
                    $display("FAIL ldr_adr: a=%0b b=%0b imm=%0b ctl=%0d need 0 01 01 0",
                             alu_src_a, alu_src_b, imm_src, alu_control);
                end
            end
            if (i == 3) begin
                checks++;
                if (adr_src !== 1'b1) begin
                    errors++;
                    $display("FAIL ldr_read: adr_src=%0b need 1", adr_src);
                end
            end
            if (i == 7) begin
                checks++;
                if ({result_src, instr_done} !== 3'b011) begin
                    errors++;
                    $display("FAIL ldr_wb: rs=%0b done=%0b need 01 1",
                             result_src, instr_done);
                end
            end
            if (i != 8) tick();
        end
    endtask

    task automatic test_subs(input logic c);
        int exp_st[5] = '{0, 1, 6, 8, 0};
        op = 2'b00; funct = 6'b000101; rd = 4'd3;
        cond_ex = c; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state_o !== 4'(exp_st[i])) begin
                errors++;
                $display("FAIL subs%0b_c%0d: state=%0d need %0d",
                         c, i, state_o, exp_st[i]);
            end
            if (i == 2) begin
                checks++;
                if ({flag_w, w2_flag_w, alu_control} !==
                    {c, c, c, 1'b0, 3'd1}) begin
                    errors++;
                    $display("FAIL subs%0b_flags: fw=%0b w2_fw=%0b ctl=%0d need %0b%0b %0b0 1",
                             c, flag_w, w2_flag_w, alu_control, c, c, c);
                end
            end
            if (i == 3) begin
                checks++;
                if ({reg_w, w2_reg_w} !== {c, c}) begin
                    errors++;
                    $display("FAIL subs%0b_wb: reg_w=%0b w2=%0b need %0b",
                             c, reg_w, w2_reg_w, c);
                end
            end
            if (i != 4) tick();
        end
    endtask

    task automatic test_eor_width();
        int exp_st[5] = '{0, 1, 6, 8, 0};
        op = 2'b00; funct = 6'b000010; rd = 4'd4;
        cond_ex = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({state_o, w2_state_o} !== {4'(exp_st[i]), 4'(exp_st[i])}) begin
                errors++;
                $display("FAIL eor_c%0d: state=%0d w2=%0d need %0d",
                         i, state_o, w2_state_o, exp_st[i]);
            end
            if (i == 1) begin
                checks++;
                if ({illegal, w2_illegal} !== 2'b01) begin
                    errors++;
                    $display("FAIL eor_illegal: ill=%0b w2=%0b need 0 1",
                             illegal, w2_illegal);
                end
            end
            if (i == 2) begin
                checks++;
                if ({alu_control, w2_alu_control} !== {3'd4, 2'd0}) begin
                    errors++;
                    $display("FAIL eor_ctl: ctl=%0d w2=%0d need 4 0",
                             alu_control, w2_alu_control);
                end
            end
            if (i == 3) begin
                checks++;
                if ({reg_w, w2_reg_w} !== 2'b10) begin
                    errors++;
                    $display("FAIL eor_wb: reg_w=%0b w2=%0b need 1 0",
                             reg_w, w2_reg_w);
                end
            end
            if (i != 4) tick();
        end
    endtask

    task automatic test_cmp();
        op = 2'b00; funct = 6'b010100; rd = 4'd5;
        cond_ex = 1'b1; mem_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({state_o, flag_w, w2_flag_w, alu_control} !==
            {4'd6, 2'b11, 2'b10, 3'd1}) begin
            errors++;
            $display("FAIL cmp_exec: state=%0d fw=%0b w2_fw=%0b ctl=%0d need 6 11 10 1",
                     state_o, flag_w, w2_flag_w, alu_control);
        end
        tick();
        checks++;
        if ({state_o, reg_w, instr_done} !== {4'd8, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL cmp_wb: state=%0d reg_w=%0b done=%0b need 8 0 1",
                     state_o, reg_w, instr_done);
        end
        tick();
    endtask

    task automatic test_movi_pc();
        op = 2'b00; funct = 6'b111010; rd = 4'd15;
        cond_ex = 1'b1; mem_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({state_o, alu_src_a, alu_src_b, imm_src, alu_control, flag_w} !==
            {4'd7, 1'b0, 2'b01, 2'b00, 3'd5, 2'b00}) begin
            errors++;
            $display("FAIL movi_exec: state=%0d a=%0b b=%0b imm=%0b ctl=%0d fw=%0b need 7 0 01 00 5 00",
                     state_o, alu_src_a, alu_src_b, imm_src, alu_control,
                     flag_w);
        end
        tick();
        checks++;
        if ({reg_w, pc_write, w2_reg_w, w2_pc_write} !== 4'b1100) begin
            errors++;
            $display("FAIL movi_wb: reg_w=%0b pc=%0b w2_reg_w=%0b w2_pc=%0b need 1 1 0 0",
                     reg_w, pc_write, w2_reg_w, w2_pc_write);
        end
        tick();
    endtask

    task automatic test_illegal_op();
        op = 2'b11; funct = 6'd0; rd = 4'd0;
        cond_ex = 1'b1; mem_ready = 1'b1;
        tick();
        checks++;
        if ({state_o, illegal, instr_done, reg_w, mem_w} !==
            {4'd1, 4'b1100}) begin
            errors++;
            $display("FAIL illop_dec: state=%0d ill=%0b done=%0b need 1 1 1",
                     state_o, illegal, instr_done);
        end
        tick();
        checks++;
        if ({state_o, illegal} !== 5'd0) begin
            errors++;
            $display("FAIL illop_next: state=%0d ill=%0b need 0 0",
                     state_o, illegal);
        end
    endtask

    task automatic test_bad_cmd();
        op = 2'b00; funct = 6'b000111; rd = 4'd6;
        cond_ex = 1'b1; mem_ready = 1'b1;
        tick();
        checks++;
        if (illegal !== 1'b1) begin
            errors++;
            $display("FAIL badcmd_dec: ill=%0b need 1", illegal);
        end
        tick();
        checks++;
        if ({state_o, flag_w, alu_control} !== {4'd6, 2'b00, 3'd0}) begin
            errors++;
            $display("FAIL badcmd_exec: state=%0d fw=%0b ctl=%0d need 6 00 0",
                     state_o, flag_w, alu_control);
        end
        tick();
        checks++;
        if ({state_o, reg_w} !== {4'd8, 1'b0}) begin
            errors++;
            $display("FAIL badcmd_wb: state=%0d reg_w=%0b need 8 0",
                     state_o, reg_w);
        end
        tick();
    endtask

    task automatic test_str(input logic c);
        int mr[7]     = '{1, 1, 1, 0, 0, 1, 1};
        int exp_st[7] = '{0, 1, 2, 5, 5, 5, 0};
        op = 2'b01; funct = 6'b000000; rd = 4'd3; cond_ex = c;
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i][0];
            #1;
            checks++;
            if (state_o !== 4'(exp_st[i])) begin
                errors++;
                $display("FAIL str%0b_c%0d: state=%0d need %0d",
                         c, i, state_o, exp_st[i]);
            end
            if (i >= 3 && i <= 5) begin
                checks++;
                if ({mem_w, adr_src, instr_done} !== {c, 1'b1, (i == 5)}) begin
                    errors++;
                    $display("FAIL str%0b_mem%0d: mem_w=%0b adr=%0b done=%0b need %0b 1 %0b",
                             c, i, mem_w, adr_src, instr_done, c, (i == 5));
                end
            end
            if (i != 6) tick();
        end
    endtask

    task automatic test_str_reset();
        op = 2'b01; funct = 6'b000000; rd = 4'd3; cond_ex = 1'b1;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick(); tick();
        checks++;
        if ({state_o, mem_w} !== {4'd5, 1'b1}) begin
            errors++;
            $display("FAIL strrst_pre: state=%0d mem_w=%0b need 5 1",
                     state_o, mem_w);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({mem_w, w2_mem_w, adr_src, state_o} !== 7'd0) begin
            errors++;
            $display("FAIL strrst_gate: mem_w=%0b w2=%0b adr=%0b state=%0d need 0",
                     mem_w, w2_mem_w, adr_src, state_o);
        end
        tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if ({state_o, w2_state_o, alu_src_b} !== {4'd0, 4'd0, 2'b10}) begin
            errors++;
            $display("FAIL strrst_after: state=%0d w2=%0d b=%0b need 0 0 10",
                     state_o, w2_state_o, alu_src_b);
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_branch(input logic c, input logic [5:0] f);
        int exp_st[5];
        int n;
        int bi;
`ifdef MCDEC_BL_EN
        if (f[4]) begin
            exp_st = '{0, 1, 10, 9, 0}; n = 5; bi = 3;
        end else begin
            exp_st = '{0, 1, 9, 0, 0}; n = 4; bi = 2;
        end
`else
        exp_st = '{0, 1, 9, 0, 0}; n = 4; bi = 2;
`endif
        op = 2'b10; funct = f; rd = 4'd0; cond_ex = c; mem_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            checks++;
            if (state_o !== 4'(exp_st[i])) begin
                errors++;
                $display("FAIL br%0b_%0h_c%0d: state=%0d need %0d",
                         c, f, i, state_o, exp_st[i]);
            end
            if (i == bi) begin
                checks++;
                if ({pc_write, imm_src, result_src, instr_done, alu_src_b} !==
                    {c, 2'b10, 2'b10, 1'b1, 2'b01}) begin
                    errors++;
                    $display("FAIL br%0b_%0h_exec: pc=%0b imm=%0b rs=%0b done=%0b b=%0b need %0b 10 10 1 01",
                             c, f, pc_write, imm_src, result_src, instr_done,
                             alu_src_b, c);
                end
            end
            if (bi == 3 && i == 2) begin
                checks++;
                if ({reg_w, imm_src, result_src, instr_done} !==
                    {c, 2'b11, 2'b10, 1'b0}) begin
                    errors++;
                    $display("FAIL br%0b_link: reg_w=%0b imm=%0b rs=%0b done=%0b need %0b 11 10 0",
                             c, reg_w, imm_src, result_src, instr_done, c);
                end
            end
            if (i != n - 1) tick();
        end
    endtask

    initial begin
        test_reset();
        test_fetch_wait();
        test_add();
        test_ldr();
        test_subs(1'b1);
        test_subs(1'b0);
        test_eor_width();
        test_cmp();
        test_movi_pc();
        test_illegal_op();
        test_bad_cmd();
        test_str(1'b1);
        test_str(1'b0);
        test_str_reset();
        test_branch(1'b1, 6'b010000);
        test_branch(1'b0, 6'b010000);
        test_branch(1'b1, 6'b000000);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
